// File: rtl/audio_pkg.sv
// Shared types and default rates for the audio sample pump.
package audio_pkg;

  // Element [1] is the right channel, element [0] the left.
  typedef logic [1:0][15:0] stereo_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE
  } pump_state_t;

  localparam int PHASE_INC_48K  = 48000;
  localparam int PHASE_MOD_720P = 74250000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_pump_if.sv
// Read-side FIFO bus between the sample pump (master) and the sample FIFO (slave).
interface audio_sample_pump_if;
  logic [31:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rd_en;

  modport master (input fifo_q, input fifo_empty, output fifo_rd_en);
  modport slave  (output fifo_q, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/audio_phase_acc.sv
// Fractional phase accumulator: one tick per audio sample period and a ~50% duty clk_audio.
module audio_phase_acc #(
  parameter int PHASE_INC = 48000,
  parameter int PHASE_MOD = 74250000,
  parameter int ACC_W     = 27
) (
  input  logic clk_pixel,
  input  logic reset,
  output logic tick,
  output logic clk_audio
);
  // ACC_W is sized so acc + PHASE_INC never overflows, so no carry bit is needed.
  localparam logic [ACC_W-1:0] INC_V  = ACC_W'(PHASE_INC);
  localparam logic [ACC_W-1:0] MOD_V  = ACC_W'(PHASE_MOD);
  localparam logic [ACC_W-1:0] HALF_V = ACC_W'(PHASE_MOD / 2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;

  assign nxt  = acc + INC_V;
  assign tick = (nxt >= MOD_V);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc       <= '0;
      clk_audio <= 1'b0;
    end else begin
      acc       <= tick ? (nxt - MOD_V) : nxt;
      clk_audio <= (acc >= HALF_V);
    end
  end

endmodule

// File: rtl/audio_sample_pump.sv
// Audio sample pump: paces FIFO pops from the clk_pixel phase accumulator and holds the stereo output.
// Build option AUDIO_UNDERRUN_MUTE_EN: an underrun tick zeroes the output word and strobes it.
module audio_sample_pump
  import audio_pkg::*;
#(
  parameter int PHASE_INC = PHASE_INC_48K,
  parameter int PHASE_MOD = PHASE_MOD_720P,
  parameter int ACC_W     = 27
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                enable,
  audio_sample_pump_if.master fifo,
  output logic                clk_audio,
  output logic                sample_strobe,
  output stereo_sample_t      audio_sample_word,
  output logic                underrun,
  output logic [15:0]         underrun_count
);

  logic        tick;
  pump_state_t state;

  audio_phase_acc #(
    .PHASE_INC (PHASE_INC),
    .PHASE_MOD (PHASE_MOD),
    .ACC_W     (ACC_W)
  ) u_phase_acc (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .tick      (tick),
    .clk_audio (clk_audio)
  );

  // The FIFO presents data the cycle after the pop, so the word is loaded at the end of
  // CAPTURE; a READ already issued always completes its capture even if enable has dropped.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state             <= ST_IDLE;
      fifo.fifo_rd_en   <= 1'b0;
      sample_strobe     <= 1'b0;
      audio_sample_word <= '0;
      underrun          <= 1'b0;
      underrun_count    <= '0;
    end else begin
      fifo.fifo_rd_en <= 1'b0;
      sample_strobe   <= 1'b0;
      underrun        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!enable) begin
            audio_sample_word <= '0;
          end else if (tick) begin
            if (fifo.fifo_empty) begin
              underrun       <= 1'b1;
              underrun_count <= sat_inc16(underrun_count);
`ifdef AUDIO_UNDERRUN_MUTE_EN
              audio_sample_word <= '0;
              sample_strobe     <= 1'b1;
`endif
            end else begin
              state           <= ST_READ;
              fifo.fifo_rd_en <= 1'b1;
            end
          end
        end

        ST_READ: begin
          state <= ST_CAPTURE;
          if (enable && tick) begin
            underrun       <= 1'b1;
            underrun_count <= sat_inc16(underrun_count);
          end
        end

        ST_CAPTURE: begin
          state             <= ST_IDLE;
          audio_sample_word <= stereo_sample_t'(fifo.fifo_q);
          sample_strobe     <= 1'b1;
          if (enable && tick) begin
            underrun       <= 1'b1;
            underrun_count <= sat_inc16(underrun_count);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_pump.sv
// Directed, table-driven bench for audio_sample_pump (PHASE_INC=1, PHASE_MOD=4) plus a
// second fast-ticking instance for counter saturation. Honours AUDIO_UNDERRUN_MUTE_EN.
module tb_audio_sample_pump;
  import audio_pkg::*;

  localparam int NVEC = 36;

  typedef struct {
    logic        enable;
    logic        fifo_empty;
    logic        exp_rd_en;
    logic        exp_strobe;
    logic        exp_underrun;
    logic        exp_clk_audio;
    logic [31:0] exp_word;
    logic [15:0] exp_count;
  } vec_t;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic           reset;
  logic           enable;
  logic           clk_audio;
  logic           sample_strobe;
  stereo_sample_t audio_sample_word;
  logic           underrun;
  logic [15:0]    underrun_count;

  logic           reset2;
  logic           enable2;
  logic           clk_audio2;
  logic           sample_strobe2;
  stereo_sample_t audio_sample_word2;
  logic           underrun2;
  logic [15:0]    underrun_count2;

  int checks = 0;
  int errors = 0;

  audio_sample_pump_if fifo_bus ();
  audio_sample_pump_if fifo_bus2 ();

  audio_sample_pump #(.PHASE_INC(1), .PHASE_MOD(4), .ACC_W(3)) dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .enable            (enable),
    .fifo              (fifo_bus),
    .clk_audio         (clk_audio),
    .sample_strobe     (sample_strobe),
    .audio_sample_word (audio_sample_word),
    .underrun          (underrun),
    .underrun_count    (underrun_count)
  );

  // PHASE_INC == PHASE_MOD ticks on every cycle.
  audio_sample_pump #(.PHASE_INC(4), .PHASE_MOD(4), .ACC_W(4)) dut_sat (
    .clk_pixel         (clk_pixel),
    .reset             (reset2),
    .enable            (enable2),
    .fifo              (fifo_bus2),
    .clk_audio         (clk_audio2),
    .sample_strobe     (sample_strobe2),
    .audio_sample_word (audio_sample_word2),
    .underrun          (underrun2),
    .underrun_count    (underrun_count2)
  );

  // Synchronous FIFO model: q changes only on the edge that sees fifo_rd_en.
  logic [31:0] fifo_mem [6];
  int          rd_cnt = 0;

  always @(posedge clk_pixel) begin
    if (fifo_bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
  end

  assign fifo_bus.fifo_q  = (rd_cnt == 0) ? 32'hDEAD_BEEF : fifo_mem[(rd_cnt - 1) % 6];
  assign fifo_bus2.fifo_q = 32'h0000_0000;

  vec_t vec [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    enable              = v.enable;
    fifo_bus.fifo_empty = v.fifo_empty;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd_en"},    32'(fifo_bus.fifo_rd_en), 32'd0);
    checkOutput({tag, "_strobe"},   32'(sample_strobe),       32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun),            32'd0);
    checkOutput({tag, "_clk"},      32'(clk_audio),           32'd0);
    checkOutput({tag, "_word"},     32'(audio_sample_word),   32'd0);
    checkOutput({tag, "_count"},    32'(underrun_count),      32'd0);
  endtask

  initial begin
    int latency;

    fifo_mem[0] = 32'h1234_5678;
    fifo_mem[1] = 32'hAAAA_5555;
    fifo_mem[2] = 32'h0F0F_F0F0;
    fifo_mem[3] = 32'hBAD0_BAD0;
    fifo_mem[4] = 32'hCAFE_0001;
    fifo_mem[5] = 32'h0000_0000;

    // Record k drives cycle k (acc = k mod 4, tick at k mod 4 == 3) and is checked in cycle k+1.
    for (int k = 0; k < NVEC; k++) begin
      vec[k].enable        = !(k >= 24 && k <= 31);
      vec[k].fifo_empty    = (k >= 11 && k <= 19) || (k == 31);
      vec[k].exp_rd_en     = (k == 3) || (k == 7) || (k == 23) || (k == 35);
      vec[k].exp_underrun  = (k == 11) || (k == 15) || (k == 19);
      vec[k].exp_clk_audio = ((k % 4) >= 2);
      vec[k].exp_count     = (k < 11) ? 16'd0 : (k < 15) ? 16'd1 : (k < 19) ? 16'd2 : 16'd3;
`ifdef AUDIO_UNDERRUN_MUTE_EN
      vec[k].exp_strobe    = (k == 5) || (k == 9) || (k == 25) || (k == 11) || (k == 15) || (k == 19);
      vec[k].exp_word      = (k < 5)  ? 32'h0 :
                             (k < 9)  ? 32'h1234_5678 :
                             (k < 11) ? 32'hAAAA_5555 :
                             (k < 25) ? 32'h0 :
                             (k == 25) ? 32'h0F0F_F0F0 : 32'h0;
`else
      vec[k].exp_strobe    = (k == 5) || (k == 9) || (k == 25);
      vec[k].exp_word      = (k < 5)  ? 32'h0 :
                             (k < 9)  ? 32'h1234_5678 :
                             (k < 25) ? 32'hAAAA_5555 :
                             (k == 25) ? 32'h0F0F_F0F0 : 32'h0;
`endif
    end

    reset                = 1'b1;
    enable               = 1'b0;
    fifo_bus.fifo_empty  = 1'b0;
    reset2               = 1'b1;
    enable2              = 1'b0;
    fifo_bus2.fifo_empty = 1'b1;

    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    checkResetState("reset");
    reset = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vec[k]);
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      checkOutput($sformatf("v%0d_rd_en", k),    32'(fifo_bus.fifo_rd_en), 32'(vec[k].exp_rd_en));
      checkOutput($sformatf("v%0d_strobe", k),   32'(sample_strobe),       32'(vec[k].exp_strobe));
      checkOutput($sformatf("v%0d_underrun", k), 32'(underrun),            32'(vec[k].exp_underrun));
      checkOutput($sformatf("v%0d_clk", k),      32'(clk_audio),           32'(vec[k].exp_clk_audio));
      checkOutput($sformatf("v%0d_word", k),     32'(audio_sample_word),   vec[k].exp_word);
      checkOutput($sformatf("v%0d_count", k),    32'(underrun_count),      32'(vec[k].exp_count));
    end

    // The pump is now in READ (record 35 saw the pop); reset aborts it and the popped word is lost.
    reset = 1'b1;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    checkResetState("midread_reset");
    reset               = 1'b0;
    enable              = 1'b1;
    fifo_bus.fifo_empty = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      checkOutput($sformatf("post_reset%0d_strobe", i), 32'(sample_strobe),       32'd0);
      checkOutput($sformatf("post_reset%0d_word", i),   32'(audio_sample_word),   32'd0);
      checkOutput($sformatf("post_reset%0d_rd_en", i),  32'(fifo_bus.fifo_rd_en), 32'd0);
    end

    // Next tick is in the current cycle: pop next cycle, strobe with the new word two cycles later.
    latency = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      if (sample_strobe) begin
        latency = i;
        break;
      end
    end
    if (latency < 0) begin
      checkOutput("post_reset_strobe_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("post_reset_strobe_latency", 32'(latency), 32'd2);
      checkOutput("post_reset_word", 32'(audio_sample_word), 32'hCAFE_0001);
      checkOutput("post_reset_right", 32'(audio_sample_word[1]), 32'h0000_CAFE);
      checkOutput("post_reset_left",  32'(audio_sample_word[0]), 32'h0000_0001);
    end

    // Saturation: every enabled cycle of dut_sat is an underrun tick.
    reset2  = 1'b0;
    enable2 = 1'b1;
    repeat (65534) @(posedge clk_pixel);
    @(negedge clk_pixel);
    checkOutput("sat_preset_count", 32'(underrun_count2), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      checkOutput($sformatf("sat%0d_count", i),    32'(underrun_count2), 32'h0000_FFFF);
      checkOutput($sformatf("sat%0d_underrun", i), 32'(underrun2),       32'd1);
    end
    enable2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
